fetch_queue: RTL and testbench

Dual-issue instruction fetch queue between instruction memory and the two instruction decoders of the superscalar RV32I core. Buffers up to DEPTH {pc, instruction} pairs, accepts 0–2 fetched words per cycle, and presents the oldest two in program order to decoder slot 0 and slot 1. A branch/jump redirect flushes the queue.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fq_storage.sv | 47 ++++
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I front end.
//   fetch_entry_t : one buffered fetch, {pc, inst}
//   NOP_INST      : canonical NOP (addi x0, x0, 0) shown on empty decoder slots
//   FQ_DEPTH      : default fetch queue depth
package riscv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int unsigned FQ_DEPTH = 8;

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue.
// Ports:
//   clk           rising-edge clock
//   we0 / we1     write enables for the older / younger incoming word
//   waddr         write address of word 0; word 1 goes to waddr+1 (mod DEPTH)
//   wdata0/wdata1 entries to write
//   raddr0/raddr1 asynchronous read addresses
//   rdata0/rdata1 read data
// The array is intentionally not reset: validity is tracked by the
// occupancy count in the parent, so stale contents are never presented.
module fq_storage
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we0,
  input  logic         we1,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t wdata0,
  input  fetch_entry_t wdata1,
  input  logic [PW-1:0] raddr0,
  input  logic [PW-1:0] raddr1,
  output fetch_entry_t rdata0,
  output fetch_entry_t rdata1
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] waddr1;

  // Power-of-two depth: natural overflow of the pointer width is the wrap.
  assign waddr1 = waddr + PW'(1);

  always_ff @(posedge clk) begin
    if (we0) begin
      mem[waddr] <= wdata0;
    end
    if (we1) begin
      mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue.
// Buffers up to DEPTH {pc, inst} pairs between instruction memory and the
// two decoders. Accepts 0..2 words per cycle and presents the oldest two in
// program order. A redirect (flush) or reset empties the queue.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 redirect; empties the queue, beats push and pop
//   in_count              words offered this cycle (0..2)
//   in_inst0/1, in_pc0/1  offered words and their PCs, word 0 older
//   in_ready              at least two entries free (from registered count)
//   out_valid             {slot 1 valid, slot 0 valid}
//   out_inst0/1, out_pc0/1 oldest / second-oldest entry, NOP / 0 when invalid
//   out_take              entries consumed by the decoders this cycle
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  in_count,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [31:0] in_pc0,
  input  logic [31:0] in_pc1,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  input  logic [1:0]  out_take
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [1:0]    avail_n;
  logic          we0, we1;
  logic [PW-1:0] raddr1;
  fetch_entry_t  wdata0, wdata1;
  fetch_entry_t  rdata0, rdata1;

  // Only the registered count feeds in_ready, so fetch sees no path from
  // out_take; space freed by a pop is offered one cycle later.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  assign out_valid = {count_q >= CW'(2), count_q != '0};

  // Entries that can be presented this cycle (0..2).
  assign avail_n = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

  always_comb begin
    push_n = 2'd0;
    if (in_ready) begin
      push_n = in_count[1] ? 2'd2 : {1'b0, in_count[0]};
    end
    // Over-take is a decoder bug; clamp so the count can never underflow.
    pop_n = (out_take > avail_n) ? avail_n : out_take;
  end

  assign we0 = (push_n != 2'd0) && !flush && !rst;
  assign we1 = (push_n == 2'd2) && !flush && !rst;

  assign wdata0 = '{pc: in_pc0, inst: in_inst0};
  assign wdata1 = '{pc: in_pc1, inst: in_inst1};

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    count_d  = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign raddr1 = rd_ptr_q + PW'(1);

  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .waddr  (wr_ptr_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr0 (rd_ptr_q),
    .raddr1 (raddr1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // Empty slots show a harmless NOP so a decoder that ignores out_valid
  // still executes nothing.
  always_comb begin
    out_inst0 = NOP_INST;
    out_pc0   = '0;
    out_inst1 = NOP_INST;
    out_pc1   = '0;
    if (out_valid[0]) begin
      out_inst0 = rdata0.inst;
      out_pc0   = rdata0.pc;
    end
    if (out_valid[1]) begin
      out_inst1 = rdata1.inst;
      out_pc1   = rdata1.pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_count;
  logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
  logic [1:0]  out_take;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_count  (in_count),
    .in_inst0  (in_inst0),
    .in_inst1  (in_inst1),
    .in_pc0    (in_pc0),
    .in_pc1    (in_pc1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst0 (out_inst0),
    .out_inst1 (out_inst1),
    .out_pc0   (out_pc0),
    .out_pc1   (out_pc1),
    .out_take  (out_take)
  );

  int n_checks = 0;
  int n_fails  = 0;

  fetch_entry_t sb[$];   // expected queue contents, oldest first
  logic [31:0]  pc_next = 32'h0;
  int           pushed_words = 0;
  int           popped_words = 0;
  bit           started = 1'b0;

  typedef struct {
    bit         r;
    bit         f;
    int         cnt;
    int         take;
    int         set_pc;   // -1: keep running PC
    logic [1:0] ev;       // out_valid after the edge
    bit         er;       // in_ready after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(logic [31:0] pc);
    if (pc == 32'h0) return 32'h0050_0093;
    if (pc == 32'h4) return 32'h00A0_0113;
    return {pc[23:0], 8'h33};
  endfunction

  // One clock: drive, check pre-edge outputs against the scoreboard, clock,
  // update the scoreboard, optionally check post-edge valid/ready.
  task automatic step(bit r, bit f, int cnt, int take, bit chk, logic [1:0] ev, bit er);
    int size;
    int take_eff;
    bit exp_ready;
    fetch_entry_t e0, e1;
    size      = sb.size();
    take_eff  = (take > size) ? size : take;
    if (take_eff > 2) take_eff = 2;
    exp_ready = (size <= int'(DEPTH) - 2);

    rst      = r;
    flush    = f;
    in_count = 2'(cnt);
    in_pc0   = pc_next;
    in_inst0 = mk_inst(pc_next);
    in_pc1   = pc_next + 32'd4;
    in_inst1 = mk_inst(pc_next + 32'd4);
    out_take = 2'(take_eff);
    #1;

    if (started) begin
      e0 = (size >= 1) ? sb[0] : '{pc: 32'h0, inst: NOP_INST};
      e1 = (size >= 2) ? sb[1] : '{pc: 32'h0, inst: NOP_INST};
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'({size >= 2, size >= 1}));
      check("slot0", {out_pc0, out_inst0}, {e0.pc, e0.inst});
      check("slot1", {out_pc1, out_inst1}, {e1.pc, e1.inst});
    end

    @(posedge clk);
    if (r || f) begin
      sb.delete();
    end else begin
      for (int i = 0; i < take_eff; i++) void'(sb.pop_front());
      popped_words += take_eff;
      if (exp_ready) begin
        for (int i = 0; i < cnt; i++) begin
          sb.push_back('{pc: pc_next, inst: mk_inst(pc_next)});
          pc_next += 32'd4;
        end
        pushed_words += cnt;
      end
    end
    #1;
    started = 1'b1;
    if (chk) begin
      check("post_valid", 64'(out_valid), 64'(ev));
      check("post_ready", 64'(in_ready), 64'(er));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_count = '0; out_take = '0;
    in_inst0 = '0; in_inst1 = '0; in_pc0 = '0; in_pc1 = '0;

    // r, f, cnt, take, set_pc, ev, er
    vecs.push_back('{1'b1, 1'b0, 0, 0, -1, 2'b00, 1'b1});  // reset
    vecs.push_back('{1'b0, 1'b0, 0, 0, -1, 2'b00, 1'b1});  // idle
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // push pc 0,4
    vecs.push_back('{1'b0, 1'b0, 0, 0, -1, 2'b11, 1'b1});  // wait
    vecs.push_back('{1'b0, 1'b0, 0, 2, -1, 2'b00, 1'b1});  // take 2
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // fill: 2
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // 4
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // 6
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b0});  // 8, full
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b0});  // dropped, still 8
    vecs.push_back('{1'b0, 1'b0, 0, 1, -1, 2'b11, 1'b0});  // 7
    vecs.push_back('{1'b0, 1'b0, 0, 1, -1, 2'b11, 1'b1});  // 6
    vecs.push_back('{1'b0, 1'b0, 0, 2, -1, 2'b11, 1'b1});  // 4
    vecs.push_back('{1'b0, 1'b0, 0, 2, -1, 2'b11, 1'b1});  // 2
    vecs.push_back('{1'b0, 1'b0, 0, 2, -1, 2'b00, 1'b1});  // 0
    vecs.push_back('{1'b0, 1'b0, 1, 0, 16, 2'b01, 1'b1});  // odd: pc 0x10
    vecs.push_back('{1'b0, 1'b0, 2, 1, -1, 2'b11, 1'b1});  // 0x14,0x18
    vecs.push_back('{1'b0, 1'b0, 0, 1, -1, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 0, 1, -1, 2'b00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // build 5
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1, 0, -1, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 2, 2, -1, 2'b00, 1'b1});  // flush collision
    vecs.push_back('{1'b0, 1'b0, 0, 0, -1, 2'b00, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});  // build 5 again
    vecs.push_back('{1'b0, 1'b0, 2, 0, -1, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1, 0, -1, 2'b11, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 2, 2, -1, 2'b00, 1'b1});  // reset collision
    vecs.push_back('{1'b0, 1'b0, 0, 0, -1, 2'b00, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].set_pc >= 0) pc_next = 32'(vecs[i].set_pc);
      step(vecs[i].r, vecs[i].f, vecs[i].cnt, vecs[i].take, 1'b1, vecs[i].ev, vecs[i].er);
    end

    // Wrap-around: alternate push 2 / take 1 and push 0 / take 2.
    pc_next      = 32'h100;
    pushed_words = 0;
    popped_words = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 2, 1, 1'b0, 2'b00, 1'b0);
      else            step(1'b0, 1'b0, 0, 2, 1'b0, 2'b00, 1'b0);
    end

    // Sustained 2-in / 2-out throughput with no bubbles.
    step(1'b0, 1'b0, 2, 0, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2, 2, 1'b1, 2'b11, 1'b1);
    step(1'b0, 1'b0, 0, 2, 1'b1, 2'b00, 1'b1);
    check("words_pushed", 64'(pushed_words), 64'(38));
    check("words_popped", 64'(popped_words), 64'(38));
    check("last_pc", 64'(pc_next), 64'(32'h100 + 32'd4 * 32'd38));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
